// File: rtl/mor1kx_sb_drain_ctrl_if.sv
// rtl/mor1kx_sb_drain_ctrl_if.sv - data bus bundle between the store-buffer drain controller and the data bus
//
// Signals (named from the controller's point of view):
//   dbus_req_o / dbus_we_o      write request, held until ack or err
//   dbus_adr_o / dbus_dat_o     address and write data
//   dbus_bsel_o / dbus_atomic_o byte selects and atomic flag
//   dbus_ack_i / dbus_err_i     completion and bus error from the slave
// Modports: master = drain controller, slave = bus / memory side.
interface mor1kx_sb_drain_ctrl_if #(
   parameter int OPTION_OPERAND_WIDTH = 32
);
   logic                              dbus_req_o;
   logic                              dbus_we_o;
   logic [OPTION_OPERAND_WIDTH-1:0]   dbus_adr_o;
   logic [OPTION_OPERAND_WIDTH-1:0]   dbus_dat_o;
   logic [OPTION_OPERAND_WIDTH/8-1:0] dbus_bsel_o;
   logic                              dbus_atomic_o;
   logic                              dbus_ack_i;
   logic                              dbus_err_i;

   modport master (
      output dbus_req_o, dbus_we_o, dbus_adr_o, dbus_dat_o, dbus_bsel_o, dbus_atomic_o,
      input  dbus_ack_i, dbus_err_i
   );

   modport slave (
      input  dbus_req_o, dbus_we_o, dbus_adr_o, dbus_dat_o, dbus_bsel_o, dbus_atomic_o,
      output dbus_ack_i, dbus_err_i
   );
endinterface

// File: rtl/mor1kx_sb_drain_ctrl.sv
// rtl/mor1kx_sb_drain_ctrl.sv - store-buffer fill and drain controller with bus-error discard and sync
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   store_*_i / store_ack_o   LSU store request and acceptance
//   sync_i / sync_done_o      msync request (level) and "all stores retired"
//   sb_write_o, sb_*_o        buffer write side (combinational copy of the store fields)
//   sb_read_o, sb_full_i,
//   sb_empty_i, sb_*_i        buffer pop; popped entry is valid the cycle after sb_read_o
//   dbus                      data bus master (interface)
//   store_err_o, err_pc_o     one-cycle bus error pulse and PC of the faulting store
//   pending_o                 stores accepted but not yet retired
module mor1kx_sb_drain_ctrl #(
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int DEPTH_WIDTH          = 4
) (
   input  logic                              clk,
   input  logic                              rst,

   input  logic                              store_req_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]   store_adr_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]   store_dat_i,
   input  logic [OPTION_OPERAND_WIDTH/8-1:0] store_bsel_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]   store_pc_i,
   input  logic                              store_atomic_i,
   output logic                              store_ack_o,

   input  logic                              sync_i,
   output logic                              sync_done_o,

   output logic                              sb_write_o,
   output logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_o,
   output logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_o,
   output logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_o,
   output logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_o,
   output logic                              sb_atomic_o,

   output logic                              sb_read_o,
   input  logic                              sb_full_i,
   input  logic                              sb_empty_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
   input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
   input  logic                              sb_atomic_i,

   mor1kx_sb_drain_ctrl_if.master            dbus,

   output logic                              store_err_o,
   output logic [OPTION_OPERAND_WIDTH-1:0]   err_pc_o,
   output logic [DEPTH_WIDTH:0]              pending_o
);

   localparam int W = OPTION_OPERAND_WIDTH;
   // Buffer capacity plus the one store held in the bus registers.
   localparam int                    PEND_MAX_INT = (1 << DEPTH_WIDTH) + 1;
   localparam logic [DEPTH_WIDTH:0]  PEND_MAX     = PEND_MAX_INT[DEPTH_WIDTH:0];

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      BUS     = 2'd2,
      DISCARD = 2'd3
   } state_t;

   state_t state, state_next;

   logic [W-1:0]   bus_adr;
   logic [W-1:0]   bus_dat;
   logic [W/8-1:0] bus_bsel;
   logic [W-1:0]   bus_pc;
   logic           bus_atomic;

   logic bus_done;
   logic bus_fail;
   logic pend_inc;
   logic pend_dec;

   // Write side: accept whenever there is room, unless a sync is draining
   // or an earlier bus error is still flushing the buffer.
   assign store_ack_o = store_req_i & ~sb_full_i & ~sync_i & (state != DISCARD);
   assign sb_write_o  = store_ack_o;
   assign sb_adr_o    = store_adr_i;
   assign sb_dat_o    = store_dat_i;
   assign sb_bsel_o   = store_bsel_i;
   assign sb_pc_o     = store_pc_i;
   assign sb_atomic_o = store_atomic_i;

   assign dbus.dbus_req_o    = (state == BUS);
   assign dbus.dbus_we_o     = (state == BUS);
   assign dbus.dbus_adr_o    = bus_adr;
   assign dbus.dbus_dat_o    = bus_dat;
   assign dbus.dbus_bsel_o   = bus_bsel;
   assign dbus.dbus_atomic_o = bus_atomic;

   // Error wins over ack when both arrive together.
   assign bus_fail = (state == BUS) & dbus.dbus_err_i;
   assign bus_done = (state == BUS) & dbus.dbus_ack_i & ~dbus.dbus_err_i;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      sb_read_o  = 1'b0;
      case (state)
         IDLE: begin
            if (!sb_empty_i) begin
               sb_read_o  = 1'b1;
               state_next = FETCH;
            end
         end
         FETCH: begin
            state_next = BUS;
         end
         BUS: begin
            if (dbus.dbus_err_i) begin
               state_next = DISCARD;
            end else if (dbus.dbus_ack_i) begin
               // Pop the next entry in the ack cycle so only one FETCH
               // cycle separates back-to-back requests.
               if (!sb_empty_i) begin
                  sb_read_o  = 1'b1;
                  state_next = FETCH;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         DISCARD: begin
            if (!sb_empty_i)
               sb_read_o = 1'b1;
            else
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_adr    <= '0;
         bus_dat    <= '0;
         bus_bsel   <= '0;
         bus_pc     <= '0;
         bus_atomic <= 1'b0;
      end else if (state == FETCH) begin
         bus_adr    <= sb_adr_i;
         bus_dat    <= sb_dat_i;
         bus_bsel   <= sb_bsel_i;
         bus_pc     <= sb_pc_i;
         bus_atomic <= sb_atomic_i;
      end
   end

   // The pulse is one cycle wide because the FSM always leaves BUS on error.
   always_ff @(posedge clk) begin
      if (rst) begin
         store_err_o <= 1'b0;
         err_pc_o    <= '0;
      end else begin
         store_err_o <= bus_fail;
         if (bus_fail)
            err_pc_o <= bus_pc;
      end
   end

   assign pend_inc = sb_write_o;
   assign pend_dec = bus_done | bus_fail | ((state == DISCARD) & sb_read_o);

   always_ff @(posedge clk) begin
      if (rst)
         pending_o <= '0;
      else if (pend_inc && !pend_dec && pending_o != PEND_MAX)
         pending_o <= pending_o + 1'b1;
      else if (pend_dec && !pend_inc && pending_o != '0)
         pending_o <= pending_o - 1'b1;
   end

   assign sync_done_o = sync_i & (pending_o == '0) & (state == IDLE);

endmodule

// File: tb/tb_mor1kx_sb_drain_ctrl.sv
// tb/tb_mor1kx_sb_drain_ctrl.sv - directed self-checking bench for mor1kx_sb_drain_ctrl with a 16-entry buffer model
module tb_mor1kx_sb_drain_ctrl;
   localparam int W  = 32;
   localparam int D  = 4;
   localparam int SB = 1 << D;

   localparam logic [63:0] S_IDLE    = 64'd0;
   localparam logic [63:0] S_FETCH   = 64'd1;
   localparam logic [63:0] S_BUS     = 64'd2;
   localparam logic [63:0] S_DISCARD = 64'd3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           store_req_i = 1'b0;
   logic [W-1:0]   store_adr_i = '0;
   logic [W-1:0]   store_dat_i = '0;
   logic [W/8-1:0] store_bsel_i = '0;
   logic [W-1:0]   store_pc_i = '0;
   logic           store_atomic_i = 1'b0;
   logic           store_ack_o;
   logic           sync_i = 1'b0;
   logic           sync_done_o;
   logic           sb_write_o;
   logic [W-1:0]   sb_adr_o, sb_dat_o, sb_pc_o;
   logic [W/8-1:0] sb_bsel_o;
   logic           sb_atomic_o;
   logic           sb_read_o;
   logic           sb_full_i, sb_empty_i;
   logic [W-1:0]   sb_adr_i, sb_dat_i, sb_pc_i;
   logic [W/8-1:0] sb_bsel_i;
   logic           sb_atomic_i;
   logic           store_err_o;
   logic [W-1:0]   err_pc_o;
   logic [D:0]     pending_o;

   int checks = 0;
   int errors = 0;

   mor1kx_sb_drain_ctrl_if #(.OPTION_OPERAND_WIDTH(W)) dbus_if ();

   mor1kx_sb_drain_ctrl #(.OPTION_OPERAND_WIDTH(W), .DEPTH_WIDTH(D)) dut (
      .clk(clk), .rst(rst),
      .store_req_i(store_req_i), .store_adr_i(store_adr_i), .store_dat_i(store_dat_i),
      .store_bsel_i(store_bsel_i), .store_pc_i(store_pc_i), .store_atomic_i(store_atomic_i),
      .store_ack_o(store_ack_o),
      .sync_i(sync_i), .sync_done_o(sync_done_o),
      .sb_write_o(sb_write_o), .sb_adr_o(sb_adr_o), .sb_dat_o(sb_dat_o), .sb_bsel_o(sb_bsel_o),
      .sb_pc_o(sb_pc_o), .sb_atomic_o(sb_atomic_o),
      .sb_read_o(sb_read_o), .sb_full_i(sb_full_i), .sb_empty_i(sb_empty_i),
      .sb_adr_i(sb_adr_i), .sb_dat_i(sb_dat_i), .sb_bsel_i(sb_bsel_i), .sb_pc_i(sb_pc_i),
      .sb_atomic_i(sb_atomic_i),
      .dbus(dbus_if),
      .store_err_o(store_err_o), .err_pc_o(err_pc_o), .pending_o(pending_o)
   );

   always #5 clk = ~clk;

   // Store buffer model: registered pop output, shares rst with the controller.
   logic [W-1:0]   m_adr [SB];
   logic [W-1:0]   m_dat [SB];
   logic [W-1:0]   m_pc  [SB];
   logic [W/8-1:0] m_bsel[SB];
   logic           m_at  [SB];
   logic [D-1:0]   wp, rp;
   logic [D:0]     cnt;

   assign sb_full_i  = (cnt == SB[D:0]);
   assign sb_empty_i = (cnt == '0);

   always @(posedge clk) begin
      if (rst) begin
         wp <= '0; rp <= '0; cnt <= '0;
         sb_adr_i <= '0; sb_dat_i <= '0; sb_bsel_i <= '0; sb_pc_i <= '0; sb_atomic_i <= 1'b0;
      end else begin
         if (sb_write_o && !sb_full_i) begin
            m_adr[wp] <= sb_adr_o; m_dat[wp] <= sb_dat_o; m_pc[wp] <= sb_pc_o;
            m_bsel[wp] <= sb_bsel_o; m_at[wp] <= sb_atomic_o;
            wp <= wp + 1'b1;
         end
         if (sb_read_o && !sb_empty_i) begin
            sb_adr_i <= m_adr[rp]; sb_dat_i <= m_dat[rp]; sb_pc_i <= m_pc[rp];
            sb_bsel_i <= m_bsel[rp]; sb_atomic_i <= m_at[rp];
            rp <= rp + 1'b1;
         end
         cnt <= cnt + (D+1)'(sb_write_o && !sb_full_i) - (D+1)'(sb_read_o && !sb_empty_i);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [W-1:0] a, input logic [W-1:0] d, input logic [W-1:0] p,
                      input logic [W/8-1:0] b, input logic at);
      store_req_i = 1'b1; store_adr_i = a; store_dat_i = d; store_pc_i = p;
      store_bsel_i = b; store_atomic_i = at;
   endtask

   // Buffer protocol must hold every cycle.
   always @(negedge clk) begin
      if (!rst) begin
         check("read_when_empty", 64'(sb_read_o & sb_empty_i), 64'd0);
         check("write_when_full", 64'(sb_write_o & sb_full_i), 64'd0);
      end
   end

   initial begin
      int n;
      dbus_if.dbus_ack_i = 1'b0;
      dbus_if.dbus_err_i = 1'b0;

      // Reset
      tick; tick;
      rst = 1'b0;
      #1;
      check("rst_state", 64'(dut.state), S_IDLE);
      check("rst_req", 64'(dbus_if.dbus_req_o), 64'd0);
      check("rst_pending", 64'(pending_o), 64'd0);
      check("rst_err", 64'(store_err_o), 64'd0);
      check("rst_err_pc", 64'(err_pc_o), 64'd0);
      check("rst_sb_read", 64'(sb_read_o), 64'd0);

      // Single store latency: accept c0, pop c1, request c3, ack c4, idle c5
      tick;
      put(32'h100, 32'hDEADBEEF, 32'h1000, 4'hF, 1'b1);
      #1;
      check("s1_ack", 64'(store_ack_o), 64'd1);
      check("s1_write", 64'(sb_write_o), 64'd1);
      check("s1_sb_adr", 64'(sb_adr_o), 64'h100);
      check("s1_sb_dat", 64'(sb_dat_o), 64'hDEADBEEF);
      tick; store_req_i = 1'b0; #1;
      check("s1_c1_read", 64'(sb_read_o), 64'd1);
      check("s1_c1_pending", 64'(pending_o), 64'd1);
      tick;
      check("s1_c2_state", 64'(dut.state), S_FETCH);
      check("s1_c2_req", 64'(dbus_if.dbus_req_o), 64'd0);
      tick;
      check("s1_c3_req", 64'(dbus_if.dbus_req_o), 64'd1);
      check("s1_c3_we", 64'(dbus_if.dbus_we_o), 64'd1);
      check("s1_c3_adr", 64'(dbus_if.dbus_adr_o), 64'h100);
      check("s1_c3_dat", 64'(dbus_if.dbus_dat_o), 64'hDEADBEEF);
      check("s1_c3_bsel", 64'(dbus_if.dbus_bsel_o), 64'hF);
      check("s1_c3_atomic", 64'(dbus_if.dbus_atomic_o), 64'd1);
      tick; dbus_if.dbus_ack_i = 1'b1; #1;
      check("s1_c4_req_held", 64'(dbus_if.dbus_req_o), 64'd1);
      check("s1_c4_adr_held", 64'(dbus_if.dbus_adr_o), 64'h100);
      tick; dbus_if.dbus_ack_i = 1'b0; #1;
      check("s1_c5_pending", 64'(pending_o), 64'd0);
      check("s1_c5_state", 64'(dut.state), S_IDLE);
      check("s1_c5_req", 64'(dbus_if.dbus_req_o), 64'd0);

      // Fill with a stalled bus: 16 in buffer + 1 in bus registers
      n = 0;
      for (int c = 0; c < 40; c++) begin
         put(32'h200 + 32'(4*n), 32'hA000 + 32'(n), 32'h3000 + 32'(4*n), 4'h3, 1'b0);
         #1;
         if (!store_ack_o) break;
         n++;
         tick;
      end
      check("fill_count", 64'(n), 64'd17);
      check("fill_full", 64'(sb_full_i), 64'd1);
      check("fill_ack_low", 64'(store_ack_o), 64'd0);
      check("fill_pending", 64'(pending_o), 64'd17);
      tick;
      check("fill_pending_hold", 64'(pending_o), 64'd17);
      store_req_i = 1'b0;
      for (int k = 0; k < 17; k++) begin
         for (int w = 0; w < 10 && !dbus_if.dbus_req_o; w++) tick;
         check("drain_req", 64'(dbus_if.dbus_req_o), 64'd1);
         check("drain_adr", 64'(dbus_if.dbus_adr_o), 64'(32'h200 + 32'(4*k)));
         check("drain_dat", 64'(dbus_if.dbus_dat_o), 64'(32'hA000 + 32'(k)));
         dbus_if.dbus_ack_i = 1'b1;
         tick;
         dbus_if.dbus_ack_i = 1'b0;
      end
      #1;
      check("drain_pending", 64'(pending_o), 64'd0);
      check("drain_state", 64'(dut.state), S_IDLE);

      // Back-to-back: three stores, ack on first BUS cycle each
      tick;
      put(32'h400, 32'h11, 32'h4000, 4'h1, 1'b0); tick;
      put(32'h404, 32'h22, 32'h4004, 4'h2, 1'b1); tick;
      put(32'h408, 32'h33, 32'h4008, 4'h4, 1'b0); tick;
      store_req_i = 1'b0;
      #1;
      check("b2b_c3_req", 64'(dbus_if.dbus_req_o), 64'd1);
      check("b2b_c3_adr", 64'(dbus_if.dbus_adr_o), 64'h400);
      check("b2b_c3_read_noack", 64'(sb_read_o), 64'd0);
      dbus_if.dbus_ack_i = 1'b1; #1;
      check("b2b_c3_read_ack", 64'(sb_read_o), 64'd1);
      tick; dbus_if.dbus_ack_i = 1'b0; #1;
      check("b2b_c4_fetch", 64'(dut.state), S_FETCH);
      check("b2b_c4_req", 64'(dbus_if.dbus_req_o), 64'd0);
      tick;
      check("b2b_c5_req", 64'(dbus_if.dbus_req_o), 64'd1);
      check("b2b_c5_adr", 64'(dbus_if.dbus_adr_o), 64'h404);
      check("b2b_c5_atomic", 64'(dbus_if.dbus_atomic_o), 64'd1);
      check("b2b_c5_bsel", 64'(dbus_if.dbus_bsel_o), 64'h2);
      dbus_if.dbus_ack_i = 1'b1; #1;
      check("b2b_c5_read", 64'(sb_read_o), 64'd1);
      tick; dbus_if.dbus_ack_i = 1'b0; #1;
      check("b2b_c6_req", 64'(dbus_if.dbus_req_o), 64'd0);
      tick;
      check("b2b_c7_adr", 64'(dbus_if.dbus_adr_o), 64'h408);
      dbus_if.dbus_ack_i = 1'b1; #1;
      check("b2b_c7_read_empty", 64'(sb_read_o), 64'd0);
      tick; dbus_if.dbus_ack_i = 1'b0; #1;
      check("b2b_c8_state", 64'(dut.state), S_IDLE);
      check("b2b_c8_pending", 64'(pending_o), 64'd0);

      // Bus error on second of four stores, err and ack together
      tick;
      put(32'h300, 32'h50, 32'h2000, 4'hF, 1'b0); tick;
      put(32'h304, 32'h51, 32'h2004, 4'hF, 1'b0); tick;
      put(32'h308, 32'h52, 32'h2008, 4'hF, 1'b0); tick;
      put(32'h30C, 32'h53, 32'h200C, 4'hF, 1'b0);
      dbus_if.dbus_ack_i = 1'b1;
      #1;
      check("err_c3_adr", 64'(dbus_if.dbus_adr_o), 64'h300);
      tick; store_req_i = 1'b0; dbus_if.dbus_ack_i = 1'b0; #1;
      tick;
      check("err_c5_adr", 64'(dbus_if.dbus_adr_o), 64'h304);
      dbus_if.dbus_ack_i = 1'b1; dbus_if.dbus_err_i = 1'b1; #1;
      check("err_c5_no_pop", 64'(sb_read_o), 64'd0);
      tick;
      dbus_if.dbus_ack_i = 1'b0; dbus_if.dbus_err_i = 1'b0;
      put(32'h500, 32'h99, 32'h5000, 4'hF, 1'b0);
      #1;
      check("err_c6_state", 64'(dut.state), S_DISCARD);
      check("err_c6_pulse", 64'(store_err_o), 64'd1);
      check("err_c6_pc", 64'(err_pc_o), 64'h2004);
      check("err_c6_pop", 64'(sb_read_o), 64'd1);
      check("err_c6_req", 64'(dbus_if.dbus_req_o), 64'd0);
      check("err_c6_ack_low", 64'(store_ack_o), 64'd0);
      tick;
      check("err_c7_pulse_end", 64'(store_err_o), 64'd0);
      check("err_c7_pop", 64'(sb_read_o), 64'd1);
      check("err_c7_req", 64'(dbus_if.dbus_req_o), 64'd0);
      check("err_c7_ack_low", 64'(store_ack_o), 64'd0);
      tick;
      check("err_c8_no_pop", 64'(sb_read_o), 64'd0);
      check("err_c8_pending", 64'(pending_o), 64'd0);
      check("err_c8_ack_low", 64'(store_ack_o), 64'd0);
      store_req_i = 1'b0;
      tick;
      check("err_c9_state", 64'(dut.state), S_IDLE);
      check("err_c9_pc_kept", 64'(err_pc_o), 64'h2004);

      // Sync with two pending stores
      put(32'h600, 32'h60, 32'h6000, 4'hF, 1'b0); tick;
      put(32'h604, 32'h61, 32'h6004, 4'hF, 1'b0); tick;
      sync_i = 1'b1;
      put(32'h608, 32'h62, 32'h6008, 4'hF, 1'b0);
      #1;
      check("sync_ack_blocked", 64'(store_ack_o), 64'd0);
      check("sync_c2_done", 64'(sync_done_o), 64'd0);
      check("sync_c2_pending", 64'(pending_o), 64'd2);
      tick; store_req_i = 1'b0; dbus_if.dbus_ack_i = 1'b1; #1;
      check("sync_c3_done", 64'(sync_done_o), 64'd0);
      tick; dbus_if.dbus_ack_i = 1'b0; #1;
      check("sync_c4_done", 64'(sync_done_o), 64'd0);
      check("sync_c4_pending", 64'(pending_o), 64'd1);
      tick; dbus_if.dbus_ack_i = 1'b1; #1;
      check("sync_c5_req", 64'(dbus_if.dbus_req_o), 64'd1);
      check("sync_c5_done", 64'(sync_done_o), 64'd0);
      tick; dbus_if.dbus_ack_i = 1'b0; #1;
      check("sync_c6_done", 64'(sync_done_o), 64'd1);
      sync_i = 1'b0; #1;
      check("sync_released", 64'(sync_done_o), 64'd0);

      // Reset in the middle of a bus access with five pending
      tick;
      for (int i = 0; i < 5; i++) begin
         put(32'h700 + 32'(4*i), 32'h70 + 32'(i), 32'h7000, 4'hF, 1'b0);
         tick;
      end
      store_req_i = 1'b0;
      #1;
      check("rst_mid_state", 64'(dut.state), S_BUS);
      check("rst_mid_req", 64'(dbus_if.dbus_req_o), 64'd1);
      check("rst_mid_pending", 64'(pending_o), 64'd5);
      rst = 1'b1;
      tick;
      check("rst_mid_req_after", 64'(dbus_if.dbus_req_o), 64'd0);
      check("rst_mid_we_after", 64'(dbus_if.dbus_we_o), 64'd0);
      check("rst_mid_pending_after", 64'(pending_o), 64'd0);
      check("rst_mid_state_after", 64'(dut.state), S_IDLE);
      check("rst_mid_empty", 64'(sb_empty_i), 64'd1);
      check("rst_mid_adr_reg", 64'(dbus_if.dbus_adr_o), 64'd0);
      check("rst_mid_sb_read", 64'(sb_read_o), 64'd0);
      rst = 1'b0;
      tick;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
